ctrl_pipe: RTL and testbench

//  Parametrised control-signal pipeline carrying the decoded control bundle from decode through

---
 rtl/ctrl_pipe_pkg.sv | 31 +++
 rtl/ctrl_stage_reg.sv | 24 ++
 rtl/ctrl_pipe.sv | 134 +++++++++++++
 tb/tb_ctrl_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the decode-to-writeback control pipeline.
// Holds the divide FSM encoding, control-bundle field layout and the bubble constant.
package ctrl_pipe_pkg;

    // Divide FSM encoding
    typedef enum logic {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } divState_t;

    // Width of the divide residency counter
    localparam int unsigned DIV_CNT_W = 8;

    // Default control bundle width, matching the maindec/aludec output
    localparam int unsigned CTRL_W_DEF = 16;

    // Control bundle field layout, shared with maindec/aludec
    localparam int unsigned MEMTOREG_BIT   = 0;
    localparam int unsigned MEMWRITE_BIT   = 1;
    localparam int unsigned ALUSRC_BIT     = 2;
    localparam int unsigned REGDST_BIT     = 3;
    localparam int unsigned REGWRITE_BIT   = 4;
    localparam int unsigned ALUCONTROL_LSB = 5;
    localparam int unsigned ALUCONTROL_W   = 3;
    localparam int unsigned BRANCH_BIT     = 8;
    localparam int unsigned JUMP_BIT       = 9;

    // Bundle carried by an empty pipeline slot
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = {CTRL_W_DEF{1'b0}};

endpackage : ctrl_pipe_pkg

// File: rtl/ctrl_stage_reg.sv
// One pipeline slot: {valid, ctrl} register with flush > hold > load priority.
module ctrl_stage_reg #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         hold,
    input  logic [W-1:0] dIn,
    output logic [W-1:0] q
);

    // Slot register: reset and flush empty the slot, hold keeps it, else load
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!hold) begin
            q <= dIn;
        end
    end

endmodule : ctrl_stage_reg

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline from decode through STAGES downstream stages, with a
// multicycle divide that parks in stage 0 and stalls decode.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        ctrl_d,
    input  logic                     valid_d,
    input  logic                     is_div_d,
    input  logic [STAGES-1:0]        flush_i,
    output logic                     stall_d_o,
    output logic [STAGES*CTRL_W-1:0] ctrl_o,
    output logic [STAGES-1:0]        valid_o,
    output logic                     div_start_o,
    output logic                     div_busy_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);

    localparam int unsigned SLOT_W = CTRL_W + 1;

    divState_t              state;
    divState_t              stateNxt;
    logic [DIV_CNT_W-1:0]   divCnt;
    logic [DIV_CNT_W-1:0]   divCntNxt;
    logic                   divStartNxt;
    logic                   divBusy;

    logic [SLOT_W-1:0]      stageD [STAGES];
    logic [SLOT_W-1:0]      stageQ [STAGES];

    assign divBusy    = (state == DIV_RUN);
    assign stall_d_o  = divBusy;
    assign div_busy_o = divBusy;

    // Divide FSM registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            divCnt      <= '0;
            div_start_o <= 1'b0;
        end else begin
            state       <= stateNxt;
            divCnt      <= divCntNxt;
            div_start_o <= divStartNxt;
        end
    end

    // Divide FSM next state: enter on an unflushed divide, leave on count 1 or stage-0 flush
    always_comb begin
        stateNxt    = state;
        divCntNxt   = divCnt;
        divStartNxt = 1'b0;
        case (state)
            IDLE: begin
                if (valid_d && is_div_d && !flush_i[0]) begin
                    stateNxt    = DIV_RUN;
                    divCntNxt   = DIV_CNT_W'(DIV_CYCLES - 1);
                    divStartNxt = 1'b1;
                end
            end
            DIV_RUN: begin
                if (flush_i[0]) begin
                    stateNxt  = IDLE;
                    divCntNxt = '0;
                end else begin
                    divCntNxt = divCnt - DIV_CNT_W'(1);
                    if (divCnt == DIV_CNT_W'(1)) begin
                        stateNxt = IDLE;
                    end
                end
            end
            default: begin
                stateNxt  = IDLE;
                divCntNxt = '0;
            end
        endcase
    end

    // Slot inputs: decode (bubble when invalid) into stage 0, bubble into stage 1 while dividing
    always_comb begin
        stageD[0] = valid_d ? {1'b1, ctrl_d} : {1'b0, CTRL_W'(CTRL_BUBBLE)};
        for (int k = 1; k < STAGES; k++) begin
            stageD[k] = stageQ[k-1];
        end
        if (divBusy) begin
            stageD[1] = '0;
        end
    end

    // Pipeline slots; only stage 0 can hold
    for (genvar k = 0; k < STAGES; k++) begin : gStage
        ctrl_stage_reg #(
            .W(SLOT_W)
        ) uStage (
            .clk  (clk),
            .rst  (rst),
            .flush(flush_i[k]),
            .hold ((k == 0) ? divBusy : 1'b0),
            .dIn  (stageD[k]),
            .q    (stageQ[k])
        );
        assign ctrl_o[k*CTRL_W +: CTRL_W] = stageQ[k][CTRL_W-1:0];
        assign valid_o[k]                 = stageQ[k][CTRL_W];
    end

`ifdef CTRL_PIPE_PERF_EN
    // Saturating stall-cycle and flush-edge counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (divBusy && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if ((|flush_i) && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule : ctrl_pipe

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe (STAGES=3, DIV_CYCLES=4).
module tb_ctrl_pipe;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STAGES = 3;
    localparam int unsigned DIVC   = 4;
    localparam int unsigned CNT_W  = 16;

    logic                     clk;
    logic                     rst;
    logic [CTRL_W-1:0]        ctrl_d;
    logic                     valid_d;
    logic                     is_div_d;
    logic [STAGES-1:0]        flush_i;
    logic                     stall_d_o;
    logic [STAGES*CTRL_W-1:0] ctrl_o;
    logic [STAGES-1:0]        valid_o;
    logic                     div_start_o;
    logic                     div_busy_o;
    logic [CNT_W-1:0]         stall_cnt_o;
    logic [CNT_W-1:0]         flush_cnt_o;

    int checks = 0;
    int errors = 0;
    int expStall = 0;
    int expFlush = 0;

    ctrl_pipe #(
        .CTRL_W    (CTRL_W),
        .STAGES    (STAGES),
        .DIV_CYCLES(DIVC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_d     (ctrl_d),
        .valid_d    (valid_d),
        .is_div_d   (is_div_d),
        .flush_i    (flush_i),
        .stall_d_o  (stall_d_o),
        .ctrl_o     (ctrl_o),
        .valid_o    (valid_o),
        .div_start_o(div_start_o),
        .div_busy_o (div_busy_o),
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] sc(input int k);
        return ctrl_o[k*CTRL_W +: CTRL_W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CTRL_W-1:0] c, input logic v, input logic dv,
                         input logic [STAGES-1:0] f);
        ctrl_d   = c;
        valid_d  = v;
        is_div_d = dv;
        flush_i  = f;
    endtask

    task automatic checkPerf(input string tag);
`ifdef CTRL_PIPE_PERF_EN
        check({tag, "_stallcnt"}, 64'(stall_cnt_o), 64'(expStall));
        check({tag, "_flushcnt"}, 64'(flush_cnt_o), 64'(expFlush));
`else
        check({tag, "_stallcnt"}, 64'(stall_cnt_o), 64'd0);
        check({tag, "_flushcnt"}, 64'(flush_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        // Reset held for two edges with random inputs
        rst = 1'b0;
        drive(CTRL_W'($urandom), 1'b1, 1'b1, STAGES'($urandom));
        step();
        drive(CTRL_W'($urandom), 1'b1, 1'b1, STAGES'($urandom));
        step();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ctrl", 64'(ctrl_o), 64'd0);
        check("rst_stall", 64'(stall_d_o), 64'd0);
        check("rst_busy", 64'(div_busy_o), 64'd0);
        check("rst_start", 64'(div_start_o), 64'd0);
        checkPerf("rst");

        // Stream of four plain bundles, then bubbles
        rst = 1'b1;
        drive(16'h0001, 1'b1, 1'b0, 3'b000); step();
        check("s1_v", 64'(valid_o), 64'b001);
        check("s1_c0", 64'(sc(0)), 64'h1);
        drive(16'h0002, 1'b1, 1'b0, 3'b000); step();
        check("s2_v", 64'(valid_o), 64'b011);
        check("s2_c", 64'(ctrl_o), 64'h0000_0001_0002);
        drive(16'h0003, 1'b1, 1'b0, 3'b000); step();
        check("s3_v", 64'(valid_o), 64'b111);
        check("s3_c", 64'(ctrl_o), 64'h0001_0002_0003);
        drive(16'h0004, 1'b1, 1'b0, 3'b000); step();
        check("s4_c", 64'(ctrl_o), 64'h0002_0003_0004);
        drive(16'hFFFF, 1'b0, 1'b0, 3'b000); step();
        check("s5_v", 64'(valid_o), 64'b110);
        check("s5_c", 64'(ctrl_o), 64'h0003_0004_0000);
        step();
        check("s6_v", 64'(valid_o), 64'b100);
        check("s6_c2", 64'(sc(2)), 64'h4);
        step();
        check("s7_v", 64'(valid_o), 64'b000);

        // Divide: 0x0009 ahead of it, 0x0055 waiting behind it
        drive(16'h0009, 1'b1, 1'b0, 3'b000); step();
        drive(16'h00AA, 1'b1, 1'b1, 3'b000); step();
        check("d0_start", 64'(div_start_o), 64'd1);
        check("d0_busy", 64'(div_busy_o), 64'd1);
        check("d0_stall", 64'(stall_d_o), 64'd1);
        check("d0_c", 64'(ctrl_o), 64'h0000_0009_00AA);
        check("d0_v", 64'(valid_o), 64'b011);
        drive(16'h0055, 1'b1, 1'b0, 3'b000); step();
        expStall++;
        check("d1_start", 64'(div_start_o), 64'd0);
        check("d1_stall", 64'(stall_d_o), 64'd1);
        check("d1_c", 64'(ctrl_o), 64'h0009_0000_00AA);
        check("d1_v", 64'(valid_o), 64'b101);
        step();
        expStall++;
        check("d2_stall", 64'(stall_d_o), 64'd1);
        check("d2_c", 64'(ctrl_o), 64'h0000_0000_00AA);
        check("d2_v", 64'(valid_o), 64'b001);
        step();
        expStall++;
        check("d3_stall", 64'(stall_d_o), 64'd0);
        check("d3_busy", 64'(div_busy_o), 64'd0);
        check("d3_c", 64'(ctrl_o), 64'h0000_0000_00AA);
        step();
        check("d4_c", 64'(ctrl_o), 64'h0000_00AA_0055);
        check("d4_v", 64'(valid_o), 64'b011);
        check("d4_start", 64'(div_start_o), 64'd0);
        checkPerf("div");

        // Abort with a stage-0 flush on the second DIV_RUN cycle
        drive(16'h00BB, 1'b1, 1'b1, 3'b000); step();
        check("a0_busy", 64'(div_busy_o), 64'd1);
        drive(16'h0066, 1'b1, 1'b0, 3'b000); step();
        expStall++;
        check("a1_busy", 64'(div_busy_o), 64'd1);
        drive(16'h0066, 1'b1, 1'b0, 3'b001); step();
        expStall++;
        expFlush++;
        check("a2_busy", 64'(div_busy_o), 64'd0);
        check("a2_stall", 64'(stall_d_o), 64'd0);
        check("a2_v0", 64'(valid_o[0]), 64'd0);
        check("a2_c0", 64'(sc(0)), 64'h0);
        checkPerf("abort");
        drive(16'h0066, 1'b1, 1'b0, 3'b000); step();
        check("a3_c0", 64'(sc(0)), 64'h66);
        check("a3_v0", 64'(valid_o[0]), 64'd1);

        // Stage-1 flush beats the normal advance
        drive(16'h0005, 1'b1, 1'b0, 3'b000); step();
        check("f0_c", 64'(ctrl_o[2*CTRL_W-1:0]), 64'h0066_0005);
        drive(16'h0007, 1'b1, 1'b0, 3'b010); step();
        expFlush++;
        check("f1_v", 64'(valid_o), 64'b101);
        check("f1_c", 64'(ctrl_o), 64'h0066_0000_0007);
        drive(16'h0000, 1'b0, 1'b0, 3'b000); step();
        check("f2_c1", 64'(sc(1)), 64'h7);
        check("f2_v", 64'(valid_o), 64'b010);

        // Divide entry coinciding with a stage-0 flush never starts
        drive(16'h00CC, 1'b1, 1'b1, 3'b001); step();
        expFlush++;
        check("x0_start", 64'(div_start_o), 64'd0);
        check("x0_busy", 64'(div_busy_o), 64'd0);
        check("x0_v0", 64'(valid_o[0]), 64'd0);
        drive(16'h0000, 1'b0, 1'b0, 3'b000); step();
        check("x1_busy", 64'(div_busy_o), 64'd0);
        check("x1_stall", 64'(stall_d_o), 64'd0);
        checkPerf("flush");

        // Reset mid-divide abandons it and clears the counters
        drive(16'h00DD, 1'b1, 1'b1, 3'b000); step();
        check("r0_busy", 64'(div_busy_o), 64'd1);
        drive(16'h0000, 1'b0, 1'b0, 3'b000);
        rst = 1'b0; step();
        expStall = 0;
        expFlush = 0;
        check("r1_busy", 64'(div_busy_o), 64'd0);
        check("r1_valid", 64'(valid_o), 64'd0);
        check("r1_ctrl", 64'(ctrl_o), 64'd0);
        check("r1_start", 64'(div_start_o), 64'd0);
        checkPerf("rst2");
        rst = 1'b1; step();
        check("r2_stall", 64'(stall_d_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ctrl_pipe
